// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable sequence detector.
// Provides the detector state type, the length-field width helper and default settings.
package seq_det_pkg;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } seq_state_t;

   localparam int unsigned SEQ_DEF_MAX_LEN = 8;
   localparam logic [7:0]  SEQ_DEF_PATTERN = 8'b110;
   localparam int unsigned SEQ_DEF_LEN     = 3;

   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/seq_det_window.sv
// Shift window, fill counter and length-masked pattern compare for seq_detector_prog.
// match_next and fill_ge_len are combinational views of the coming edge.
module seq_det_window
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = SEQ_DEF_MAX_LEN,
   parameter int LEN_W   = len_w(MAX_LEN)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               sample,
   input  logic               din,
   input  logic               overlap,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   output logic               match_next,
   output logic               fill_ge_len
);

   logic [MAX_LEN-1:0] hist;
   logic [MAX_LEN-1:0] hist_next;
   logic [MAX_LEN-1:0] mask;
   logic [LEN_W-1:0]   fill;
   logic [LEN_W-1:0]   fill_next;

   always_comb begin
      hist_next = {hist[MAX_LEN-2:0], din};
      fill_next = fill;
      mask      = '0;
      if (sample && (fill != LEN_W'(MAX_LEN))) begin
         fill_next = fill + 1'b1;
      end
      // only the newest len bits of the window take part in the compare
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < int'(len));
      end
      fill_ge_len = (fill_next >= len);
      match_next  = sample && fill_ge_len &&
                    ((hist_next & mask) == (pattern & mask));
   end

   always_ff @(posedge clock) begin
      if (!reset || clear) begin
         hist <= '0;
         fill <= '0;
      end else if (sample) begin
         hist <= hist_next;
         fill <= (match_next && !overlap) ? '0 : fill_next;
      end
   end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial bit-pattern detector with registered 1-cycle match pulse.
// Optional saturating match counter enabled by defining SEQ_MATCH_COUNT_EN.
//
//   state | meaning
//   FILL  | window holds fewer than len fresh bits; no match possible yet
//   FULL  | window holds at least len bits; every sample is compared
module seq_detector_prog
   import seq_det_pkg::*;
#(
   parameter int                MAX_LEN     = SEQ_DEF_MAX_LEN,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(SEQ_DEF_PATTERN),
   parameter int                DEF_LEN     = SEQ_DEF_LEN,
   parameter logic              DEF_OVERLAP = 1'b1,
   parameter int                CNT_W       = 16,
   localparam int               LEN_W       = len_w(MAX_LEN)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in,
   input  logic               in_valid,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   output logic               out,
   output logic               armed,
   output logic               cfg_err
`ifdef SEQ_MATCH_COUNT_EN
   ,
   output logic [CNT_W-1:0]   match_count
`endif
);

   if (MAX_LEN < 2 || DEF_LEN < 1 || DEF_LEN > MAX_LEN || CNT_W < 1) begin : g_param_err
      $error("seq_detector_prog: illegal parameter set");
   end

   seq_state_t         state;
   seq_state_t         state_next;
   logic [MAX_LEN-1:0] pattern_q;
   logic [LEN_W-1:0]   len_q;
   logic               overlap_q;
   logic               cfg_err_q;
   logic               out_q;
   logic               out_next;
   logic               sample;
   logic               len_ok;
   logic               match_next;
   logic               fill_ge_len;

   // a load takes priority over data; the bit presented with it is dropped
   assign sample = in_valid && !cfg_load;
   assign len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

   seq_det_window #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_window (
      .clock       (clock),
      .reset       (reset),
      .clear       (cfg_load),
      .sample      (sample),
      .din         (in),
      .overlap     (overlap_q),
      .pattern     (pattern_q),
      .len         (len_q),
      .match_next  (match_next),
      .fill_ge_len (fill_ge_len)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         pattern_q <= DEF_PATTERN;
         len_q     <= LEN_W'(DEF_LEN);
         overlap_q <= DEF_OVERLAP;
         cfg_err_q <= 1'b0;
      end else if (cfg_load) begin
         pattern_q <= cfg_pattern;
         overlap_q <= cfg_overlap;
         len_q     <= len_ok ? cfg_len : LEN_W'(MAX_LEN);
         cfg_err_q <= !len_ok;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= FILL;
         out_q <= 1'b0;
      end else begin
         state <= state_next;
         out_q <= out_next;
      end
   end

   always_comb begin
      state_next = state;
      out_next   = match_next;
      if (cfg_load) begin
         state_next = FILL;
      end else begin
         case (state)
            FILL: begin
               if (fill_ge_len && !(match_next && !overlap_q)) begin
                  state_next = FULL;
               end
            end
            FULL: begin
               // non-overlapping mode throws the window away after a hit
               if (match_next && !overlap_q) begin
                  state_next = FILL;
               end
            end
            default: state_next = FILL;
         endcase
      end
   end

   assign out     = out_q;
   assign armed   = (state == FULL);
   assign cfg_err = cfg_err_q;

`ifdef SEQ_MATCH_COUNT_EN
   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clock) begin
      if (!reset || cfg_load) begin
         count_q <= '0;
      end else if (match_next && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign match_count = count_q;
`endif

endmodule
